// File: rtl/fetch_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_unit_if : fetch-stage bus (memory, pipeline, control)      |
// | Revision 1.0                                                     |
// +-----------------------------------------------------------------+
interface fetch_unit_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) ();
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic [DATA_W-1:0] ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic              ifid_valid;
  logic              fetch_busy;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_busy
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_busy
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_unit : PC owner, waits for slow imem, fills IF/ID register |
// | Revision 1.0                                                     |
// +-----------------------------------------------------------------+
module fetch_unit #(
  parameter int              ADDR_W      = 13,
  parameter int              DATA_W      = 16,
  parameter int              WAIT_CYCLES = 7,
  parameter logic [DATA_W-1:0] NOP       = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [0:0] {
    S_WAIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [3:0] c_cnt_last = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    if (bus.redirect) begin
      // Redirect overrides stall and discards whatever is in flight.
      pc_d    = bus.redirect_pc;
      cnt_d   = '0;
      state_d = S_WAIT;
      instr_d = NOP;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == c_cnt_last) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
          if (!bus.stall) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end
        S_READY: begin
          if (!bus.stall) begin
            instr_d = bus.imem_instr;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= NOP;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc    = ifpc_q;
  assign bus.ifid_valid = valid_q;
  assign bus.fetch_busy = (state_q == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fetch_unit : scoreboard bench for fetch_unit                  |
// | Revision 1.0                                                     |
// +-----------------------------------------------------------------+
module tb_fetch_unit;

  logic clk;
  logic reset_n;

  fetch_unit_if #(.ADDR_W(13), .DATA_W(16)) bus ();

  fetch_unit #(
    .ADDR_W(13), .DATA_W(16), .WAIT_CYCLES(7), .NOP(16'h0000)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Memory image: address i holds 0x1000 + i.
  assign bus.imem_instr = 16'h1000 + 16'(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] pc;
    logic [15:0] instr;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_exp(input logic [12:0] pc, input int at_cyc);
    exp_t e;
    e.pc    = pc;
    e.instr = 16'h1000 + 16'(pc);
    e.cyc   = at_cyc;
    sb_q.push_back(e);
  endtask

  // One clock edge; a valid IF/ID after an unstalled edge is a fresh capture.
  task automatic step();
    logic st;
    exp_t e;
    st = bus.stall;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ifid_valid && !st) begin
      if (sb_q.size() == 0) begin
        check_value("unexpected_capture", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_value("cap_pc",    32'(bus.ifid_pc),    32'(e.pc));
        check_value("cap_instr", 32'(bus.ifid_instr), 32'(e.instr));
        check_value("cap_cycle", 32'(cyc),            32'(e.cyc));
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic check_drained(input string tag);
    check_value(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset_n = 1'b0;
    #3;
    check_value("rst_addr",  32'(bus.imem_addr),  32'd0);
    check_value("rst_valid", 32'(bus.ifid_valid), 32'd0);
    check_value("rst_instr", 32'(bus.ifid_instr), 32'd0);
    check_value("rst_ifpc",  32'(bus.ifid_pc),    32'd0);
    check_value("rst_busy",  32'(bus.fetch_busy), 32'd1);

    // Free-run: one capture every 8 edges.
    do_reset();
    push_exp(13'd0, 8);
    push_exp(13'd1, 16);
    push_exp(13'd2, 24);
    steps(24);
    check_drained("freerun_drained");

    // Stall from edge 7 through edge 10 while address 0 becomes ready.
    do_reset();
    steps(6);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_value("stall_addr",  32'(bus.imem_addr),  32'd0);
      check_value("stall_valid", 32'(bus.ifid_valid), 32'd0);
    end
    check_value("stall_ready", 32'(bus.fetch_busy), 32'd0);
    bus.stall = 1'b0;
    push_exp(13'd0, 11);
    step();
    bus.stall = 1'b1;
    push_exp(13'd1, 19);
    steps(2);
    check_value("stall_hold_valid", 32'(bus.ifid_valid), 32'd1);
    check_value("stall_hold_instr", 32'(bus.ifid_instr), 32'h1000);
    bus.stall = 1'b0;
    step();
    check_value("stall_bubble", 32'(bus.ifid_valid), 32'd0);
    steps(5);
    check_drained("stall_drained");

    // Redirect during WAIT at edge 3.
    do_reset();
    steps(2);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 13'h0100;
    step();
    bus.redirect = 1'b0;
    check_value("redir_addr",  32'(bus.imem_addr),  32'h0100);
    check_value("redir_valid", 32'(bus.ifid_valid), 32'd0);
    check_value("redir_busy",  32'(bus.fetch_busy), 32'd1);
    push_exp(13'h0100, 11);
    steps(8);
    check_drained("redir_drained");

    // Redirect together with stall while READY holding a valid instruction.
    do_reset();
    push_exp(13'd0, 8);
    steps(8);
    bus.stall = 1'b1;
    steps(8);
    check_value("rs_pre_valid", 32'(bus.ifid_valid), 32'd1);
    check_value("rs_pre_ready", 32'(bus.fetch_busy), 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 13'h0005;
    step();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    check_value("rs_flush_valid", 32'(bus.ifid_valid), 32'd0);
    check_value("rs_flush_instr", 32'(bus.ifid_instr), 32'h0000);
    check_value("rs_addr",        32'(bus.imem_addr),  32'h0005);
    push_exp(13'h0005, 25);
    steps(8);
    check_drained("rs_drained");

    // Wrap-around from 0x1FFF to 0.
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 13'h1FFF;
    step();
    bus.redirect = 1'b0;
    push_exp(13'h1FFF, 9);
    push_exp(13'h0000, 17);
    steps(8);
    check_value("wrap_addr", 32'(bus.imem_addr), 32'h0000);
    steps(8);
    check_drained("wrap_drained");

    // Asynchronous reset while READY with a valid IF/ID.
    do_reset();
    push_exp(13'd0, 8);
    steps(8);
    bus.stall = 1'b1;
    steps(7);
    check_value("ar_pre_valid", 32'(bus.ifid_valid), 32'd1);
    check_value("ar_pre_ready", 32'(bus.fetch_busy), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("ar_valid", 32'(bus.ifid_valid), 32'd0);
    check_value("ar_instr", 32'(bus.ifid_instr), 32'h0000);
    check_value("ar_ifpc",  32'(bus.ifid_pc),    32'd0);
    check_value("ar_addr",  32'(bus.imem_addr),  32'd0);
    check_value("ar_busy",  32'(bus.fetch_busy), 32'd1);
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    push_exp(13'd0, 8);
    steps(8);
    check_drained("ar_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the 8K x 16 instruction memory. Owns the 13-bit program counter and drives the memory address. Waits a fixed number of cycles for the slow asynchronous memory read to settle, then captures the instruction into the IF/ID pipeline register. Supports decode-stage stall and branch/jump redirect with flush.

## Interface
- ADDR_W, 13: PC and instruction-memory address width.
- DATA_W, 16: instruction width.
- WAIT_CYCLES, 7: cycles allowed for the memory read to settle after each address change. Legal range is 1..15; 7 covers 65 ns at a 10 ns clock.
- NOP, 16'h0000: encoding inserted into IF/ID on bubble or flush.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hazard; when 1, IF/ID holds and no capture occurs.
- redirect  in  1  taken branch/jump; when 1, loads the PC from redirect_pc.
- redirect_pc  in  ADDR_W  redirect target address.
- imem_addr  out  ADDR_W  address to the instruction memory; registered.
- imem_instr  in  DATA_W  instruction returned by the memory.
- ifid_instr  out  DATA_W  IF/ID instruction register.
- ifid_pc  out  ADDR_W  IF/ID address of ifid_instr.
- ifid_valid  out  1  ifid_instr is a real fetched instruction; 0 means bubble.
- fetch_busy  out  1  high while in the WAIT state.

## Operation
- State machine has two states, WAIT and READY.
- Internal registers: pc (ADDR_W), cnt (4 bits).
- imem_addr always equals pc.
- **Reset** (reset_n=0, asynchronous):
  - pc=0, imem_addr=0, cnt=0, state=WAIT.
  - ifid_instr=NOP, ifid_pc=0, ifid_valid=0, fetch_busy=1.
- **WAIT**:
  - cnt increments each edge.
  - On the edge where cnt==WAIT_CYCLES-1, go to READY and clear cnt.
  - IF/ID: if stall=0, load a bubble (instr=NOP, valid=0, ifid_pc unchanged). If stall=1, hold.
- **READY**, stall=0:
  - Capture ifid_instr=imem_instr, ifid_pc=pc, ifid_valid=1.
  - pc=pc+1, cnt=0, state=WAIT.
- **READY**, stall=1:
  - Hold everything; remain in READY.
  - The memory output stays stable because the address is unchanged.
- **redirect=1** has the highest priority in any state and regardless of stall:
  - pc=redirect_pc, cnt=0, state=WAIT.
  - ifid_instr=NOP, ifid_valid=0, ifid_pc unchanged.
  - Any in-flight or ready instruction is discarded.
- PC arithmetic is modulo 2^ADDR_W: 8191+1 wraps to 0 with no flag.
- fetch_busy = (state==WAIT), decoded combinationally from the state register.

## Timing
- imem_addr changes only on a clock edge (edge k).
- The instruction is captured at edge k+WAIT_CYCLES+1 at the earliest.
- Peak throughput is one instruction per WAIT_CYCLES+1 cycles; 8 cycles at default.
- Each stall cycle in READY adds one cycle.
- Redirect latency: target address is on imem_addr the cycle after the redirect edge. The first target instruction appears in IF/ID WAIT_CYCLES+1 edges after that.
- Simultaneous redirect and a READY capture: redirect wins and nothing is captured.
- Simultaneous redirect and stall: redirect wins and IF/ID is flushed.
- Reset mid-WAIT or mid-READY: all outputs return to their reset values immediately, without waiting for a clock edge.
- After reset release, the first fetch is address 0. It is captured at the (WAIT_CYCLES+1)th edge.

## Test plan
- **Reset then free-run**, memory preloaded with 0x1000+i at address i, stall=0:
  - After reset, imem_addr=0 and ifid_valid=0.
  - ifid shows (pc 0, 0x1000) at edge 8, (pc 1, 0x1001) at edge 16, and so on.
  - ifid_valid is high for exactly one cycle per fetch.
- **Stall in READY**:
  - Assert stall from edge 7 to edge 10.
  - IF/ID holds its old contents and imem_addr stays 0.
  - Capture of 0x1000 occurs on the first edge with stall=0.
- **Redirect during WAIT**:
  - Assert redirect with redirect_pc=0x0100 at edge 3.
  - imem_addr=0x0100 next cycle and ifid_valid=0.
  - ifid holds (pc 0x0100, 0x1100) 8 edges later.
  - Address 0's instruction never appears.
- **Redirect plus stall in READY**:
  - Assert both with redirect_pc=0x0005.
  - IF/ID is flushed to NOP with valid=0.
  - The next capture is address 5.
- **Wrap-around**:
  - Redirect to 0x1FFF.
  - Capture pc 0x1FFF, then imem_addr=0x0000, and the next capture has pc 0.
- **Async reset mid-operation**:
  - Drop reset_n between clock edges while in READY with ifid_valid=1.
  - Outputs go to their reset values immediately, before the next edge.
  - Fetch restarts at address 0 after release.
